// File: rtl/ball_flight_pkg.sv
// Shared types and default geometry for the ball trajectory generator and its consumers.
// The analyzer zone constants live here so the producer and the scorer agree on them.
package ball_flight_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOWL,
        S_HIT,
        S_DONE
    } flight_state_t;

    localparam int DEF_TICK_DIV  = 833333;
    localparam int DEF_START_X   = 300;
    localparam int DEF_STEP_X    = 4;
    localparam int DEF_WICKET_X  = 7;
    localparam int DEF_HIT_MIN   = 8;
    localparam int DEF_HIT_MAX   = 22;
    localparam int DEF_HIT_TICKS = 16;
    localparam int DEF_X_MAX     = 319;

    // Analyzer zones: a ball at the stumps inside OUT_Y is an out, ZERO_Y scores nothing.
    localparam int OUT_Y_MIN = 175;
    localparam int OUT_Y_MAX = 230;
    localparam int ZERO_Y    = 160;

    function automatic logic [7:0] lane_y(input logic [1:0] lane);
        logic [7:0] y;
        case (lane)
            2'd0:    y = 8'd160;
            2'd1:    y = 8'd180;
            2'd2:    y = 8'd200;
            default: y = 8'd220;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/motion_tick_gen.sv
// Free-running divider producing a one-cycle motion tick every TICK_DIV clocks.
// Shared with the sprite drawer so both animate on the same cadence.
module motion_tick_gen
    import ball_flight_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/ball_flight_gen.sv
// Delivery trajectory generator: bowls the ball toward the stumps, handles the bat swing,
// flies a hit ball rightward, and reports the final coordinates with a strike pulse.
module ball_flight_gen
    import ball_flight_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int START_X   = DEF_START_X,
    parameter int STEP_X    = DEF_STEP_X,
    parameter int WICKET_X  = DEF_WICKET_X,
    parameter int HIT_MIN   = DEF_HIT_MIN,
    parameter int HIT_MAX   = DEF_HIT_MAX,
    parameter int HIT_TICKS = DEF_HIT_TICKS,
    parameter int X_MAX     = DEF_X_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bowl,
    input  logic       bat,
    input  logic [1:0] bat_power,
    input  logic [1:0] lane,
    input  logic       game_over,
    output logic       throw,
    output logic       strike,
    output logic [8:0] pixelx,
    output logic [7:0] pixely,
    output logic       ball_active
);

    localparam int FW = $clog2(HIT_TICKS + 1);

    localparam logic [8:0]    START_V   = 9'(START_X);
    localparam logic [8:0]    STEP_V    = 9'(STEP_X);
    localparam logic [8:0]    WICKET_V  = 9'(WICKET_X);
    localparam logic [8:0]    HIT_MIN_V = 9'(HIT_MIN);
    localparam logic [8:0]    HIT_MAX_V = 9'(HIT_MAX);
    localparam logic [8:0]    X_MAX_V   = 9'(X_MAX);
    localparam logic [9:0]    X_MAX_W   = 10'(X_MAX);
    localparam logic [9:0]    CLAMP_TH  = 10'(WICKET_X + STEP_X);
    localparam logic [FW-1:0] FLIGHT_V  = FW'(HIT_TICKS);
    localparam logic [FW-1:0] FLIGHT_1  = FW'(1);

    flight_state_t state, state_n;

    logic          bowl_q, bat_q;
    logic          bowl_edge, bat_edge;
    logic          tick;
    logic [8:0]    px, px_n;
    logic [7:0]    py, py_n;
    logic          throw_q, throw_n;
    logic          swing_used, swing_n;
    logic [3:0]    vx, vx_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [9:0]    fly_sum;
    logic          in_window;

    motion_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign bowl_edge = bowl & ~bowl_q;
    assign bat_edge  = bat & ~bat_q;
    assign in_window = (px >= HIT_MIN_V) && (px <= HIT_MAX_V);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            bowl_q     <= 1'b0;
            bat_q      <= 1'b0;
            px         <= '0;
            py         <= '0;
            throw_q    <= 1'b0;
            swing_used <= 1'b0;
            vx         <= '0;
            fcnt       <= '0;
        end else begin
            state      <= state_n;
            bowl_q     <= bowl;
            bat_q      <= bat;
            px         <= px_n;
            py         <= py_n;
            throw_q    <= throw_n;
            swing_used <= swing_n;
            vx         <= vx_n;
            fcnt       <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        px_n    = px;
        py_n    = py;
        throw_n = 1'b0;
        swing_n = swing_used;
        vx_n    = vx;
        fcnt_n  = fcnt;
        fly_sum = {1'b0, px} + {6'd0, vx};

        case (state)
            S_IDLE: begin
                if (bowl_edge && !game_over) begin
                    state_n = S_BOWL;
                    throw_n = 1'b1;
                    px_n    = START_V;
                    py_n    = lane_y(lane);
                    swing_n = 1'b0;
                end
            end

            S_BOWL: begin
                // A connecting swing wins over a coincident tick: the ball is hit where it is.
                if (bat_edge && !swing_used && in_window) begin
                    state_n = S_HIT;
                    vx_n    = {1'b0, bat_power, 1'b0} + 4'd2;
                    fcnt_n  = FLIGHT_V;
                end else begin
                    if (bat_edge)
                        swing_n = 1'b1;
                    if (tick) begin
                        if (px == WICKET_V)
                            state_n = S_DONE;
                        else if ({1'b0, px} < CLAMP_TH)
                            px_n = WICKET_V;
                        else
                            px_n = px - STEP_V;
                    end
                end
            end

            S_HIT: begin
                if (tick) begin
                    px_n   = (fly_sum > X_MAX_W) ? X_MAX_V : fly_sum[8:0];
                    fcnt_n = fcnt - 1'b1;
                    if (fcnt <= FLIGHT_1)
                        state_n = S_DONE;
                end
            end

            S_DONE: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase
    end

    assign throw       = throw_q;
    assign strike      = (state == S_DONE);
    assign ball_active = (state == S_BOWL) || (state == S_HIT);
    assign pixelx      = px;
    assign pixely      = py;

endmodule

// File: tb/tb_ball_flight_gen.sv
// Delivery-level checks of ball_flight_gen: directed table, corner sequences, random deliveries.
module tb_ball_flight_gen;

    localparam int TDIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bowl = 1'b0, bat = 1'b0, game_over = 1'b0;
    logic [1:0] bat_power = 2'd0, lane = 2'd0;
    logic       throw, strike, ball_active;
    logic [8:0] pixelx;
    logic [7:0] pixely;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic tick_now;

    ball_flight_gen #(.TICK_DIV(TDIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .bowl       (bowl),
        .bat        (bat),
        .bat_power  (bat_power),
        .lane       (lane),
        .game_over  (game_over),
        .throw      (throw),
        .strike     (strike),
        .pixelx     (pixelx),
        .pixely     (pixely),
        .ball_active(ball_active)
    );

    always #5 clock = ~clock;

    // Independent view of the motion tick: one tick every TDIV cycles counted from reset.
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;
    assign tick_now = ((cyc % TDIV) == (TDIV - 1));

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: bowled position after n ticks, and landing point of a delivery.
    function automatic int bowl_x(input int n);
        int v;
        v = 300 - 4 * n;
        return (v < 7) ? 7 : v;
    endfunction

    function automatic bit connects(input int x);
        return (x >= 8) && (x <= 22);
    endfunction

    function automatic int final_x(input int n1, input int pw);
        int x;
        if (n1 < 0) return 7;
        x = bowl_x(n1);
        if (!connects(x)) return 7;
        x = x + 16 * 2 * (pw + 1);
        return (x > 319) ? 319 : x;
    endfunction

    // One full delivery. n1/n2: tick count at which the bat is pressed (-1 = never).
    // sync: hold the first press until the cycle carrying a tick. gom: raise game_over mid-flight.
    task automatic run_delivery(input int lane_i, input int pw, input int n1, input int n2,
                                input bit sync, input bit gom, input int ex, input int ey,
                                input string tag);
        int ta = 0, throws = 0, strikes = 0, sx = -1, sy = -1, guard = 0, tail = 0;
        logic sa = 1'b1;
        bit pressed1 = 0, pressed2 = 0, hitp = 0, path_bad = 0, done = 0;
        lane      = 2'(lane_i);
        bat_power = 2'(pw);
        bat       = 1'b0;
        @(negedge clock); bowl = 1'b1;
        @(negedge clock); bowl = 1'b0;
        check({tag, "_throw_first"}, throw, 1);
        check({tag, "_active_at_throw"}, ball_active, 1);
        while (tail < 4 && guard < 3000) begin
            if (throw) throws++;
            if (strike) begin
                strikes++;
                sx = pixelx; sy = pixely; sa = ball_active;
                done = 1;
            end
            if (!done && !hitp && (pixelx != 9'(bowl_x(ta)))) path_bad = 1;
            if (gom && ta == 10) game_over = 1'b1;
            if (bat) begin
                bat = 1'b0;
            end else if (!done) begin
                if (!pressed1 && n1 >= 0 && ta == n1 && (!sync || tick_now)) begin
                    bat = 1'b1; pressed1 = 1;
                    hitp = connects(bowl_x(n1));
                end else if (pressed1 && !pressed2 && n2 >= 0 && ta == n2) begin
                    bat = 1'b1; pressed2 = 1;
                end
            end
            if (tick_now) ta++;
            if (done) tail++;
            guard++;
            @(negedge clock);
        end
        check({tag, "_throw_count"}, throws, 1);
        check({tag, "_strike_count"}, strikes, 1);
        check({tag, "_strike_x"}, sx, ex);
        check({tag, "_strike_y"}, sy, ey);
        check({tag, "_active_in_strike"}, sa, 0);
        check({tag, "_bowl_path"}, path_bad, 0);
        check({tag, "_hold_x"}, pixelx, ex);
        game_over = 1'b0;
        bat       = 1'b0;
    endtask

    typedef struct {
        int lane;
        int pw;
        int n1;
        int n2;
        bit sync;
        bit gom;
        int ex;
        int ey;
    } vec_t;

    vec_t vt[8];

    initial begin
        int throws, strikes, act, hold_x, hold_y, ta, guard;
        int rl, rp, r1, r2;
        bit rs, rg;

        vt[0] = '{2, 0, -1, -1, 0, 0,   7, 200};  // clean miss to the stumps
        vt[1] = '{1, 1, 70, -1, 0, 0,  84, 180};  // hit at x=20, vx=4
        vt[2] = '{0, 2, 50, 70, 0, 0,   7, 160};  // early swing burns the only attempt
        vt[3] = '{3, 3, 70, -1, 1, 0, 148, 220};  // hit on a tick cycle, vx=8
        vt[4] = '{0, 0, 73, -1, 0, 0,  40, 160};  // hit at x=8, lowest connecting x
        vt[5] = '{2, 2, 69, -1, 0, 0,   7, 200};  // x=24 just past the window
        vt[6] = '{1, 3, 74, -1, 0, 0,   7, 180};  // x=7 below the window
        vt[7] = '{3, 2, 71, -1, 0, 1, 112, 220};  // game_over mid-flight does not abort

        repeat (3) @(negedge clock);
        check("reset_throw", throw, 0);
        check("reset_strike", strike, 0);
        check("reset_active", ball_active, 0);
        check("reset_x", pixelx, 0);
        check("reset_y", pixely, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_delivery(vt[i].lane, vt[i].pw, vt[i].n1, vt[i].n2, vt[i].sync, vt[i].gom,
                         vt[i].ex, vt[i].ey, $sformatf("vec%0d", i));

        // Bowling is refused while the game is over; coordinates keep the last landing.
        hold_x = vt[7].ex;
        hold_y = vt[7].ey;
        game_over = 1'b1;
        lane = 2'd0;
        @(negedge clock); bowl = 1'b1;
        @(negedge clock); bowl = 1'b0;
        throws = 0; act = 0;
        for (int c = 0; c < 20; c++) begin
            if (throw) throws++;
            if (ball_active) act++;
            @(negedge clock);
        end
        check("gameover_throws", throws, 0);
        check("gameover_active", act, 0);
        check("gameover_hold_x", pixelx, hold_x);
        check("gameover_hold_y", pixely, hold_y);
        game_over = 1'b0;
        run_delivery(0, 1, -1, -1, 0, 0, 7, 160, "after_gameover");

        // Reset in the middle of a delivery at x=200.
        lane = 2'd1;
        @(negedge clock); bowl = 1'b1;
        @(negedge clock); bowl = 1'b0;
        ta = 0; guard = 0;
        while (ta < 25 && guard < 1000) begin
            if (tick_now) ta++;
            guard++;
            @(negedge clock);
        end
        check("midreset_x_before", pixelx, 200);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_outputs", {throw, strike, ball_active, pixelx, pixely}, 0);
        reset = 1'b0;
        throws = 0; strikes = 0; act = 0;
        for (int c = 0; c < 100 * TDIV; c++) begin
            if (throw) throws++;
            if (strike) strikes++;
            if (ball_active) act++;
            @(negedge clock);
        end
        check("midreset_no_strike", strikes, 0);
        check("midreset_no_throw", throws, 0);
        check("midreset_idle", act, 0);

        // Random deliveries against the landing-point model.
        for (int k = 0; k < 12; k++) begin
            rl = $urandom_range(0, 3);
            rp = $urandom_range(0, 3);
            r1 = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(60, 74);
            r2 = -1;
            if (r1 >= 0 && r1 < 74 && !connects(bowl_x(r1)) && $urandom_range(0, 1) == 1)
                r2 = $urandom_range(r1 + 1, 74);
            rs = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            run_delivery(rl, rp, r1, r2, rs, rg, final_x(r1, rp), 160 + 20 * rl,
                         $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ball_flight_gen.md
Name: ball_flight_gen

Overview:
Producer side of the hit/score interface. Generates each delivery's ball trajectory, and drives the throw pulse, strike pulse and final pixelx/pixely consumed by the game analyzer. It also feeds live coordinates to the VGA sprite drawer. The block sits between the debounced player buttons and the analyzer's run detector, ball counter and score keeper.

Parameters:
TICK_DIV, 833333, clock cycles per motion tick (60 Hz at 50 MHz); benches use 4.
START_X, 300, pixelx where each delivery starts.
STEP_X, 4, leftward pixels per tick while bowling.
WICKET_X, 7, pixelx of the stumps; clamp floor for a missed ball.
HIT_MIN, 8, lowest pixelx at which a bat press connects.
HIT_MAX, 22, highest pixelx at which a bat press connects.
HIT_TICKS, 16, ticks of rightward flight after a hit.
X_MAX, 319, saturation ceiling for pixelx.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
bowl  in  1  debounced bowl button, level
bat  in  1  debounced bat button, level
bat_power  in  2  shot power; rightward speed vx = 2*(bat_power+1) px/tick
lane  in  2  delivery height; pixely = 160 + 20*lane (160/180/200/220)
game_over  in  1  from over counter; blocks new deliveries
throw  out  1  one-cycle pulse at delivery start
strike  out  1  one-cycle pulse when ball resolves; pixelx/pixely final in that cycle
pixelx  out  9  ball x
pixely  out  8  ball y
ball_active  out  1  high in BOWL and HIT

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - Outputs: throw=0, strike=0, pixelx=0, pixely=0, ball_active=0.
  - State IDLE; tick counter 0; edge registers 0; swing_used=0.
  - Reset mid-flight aborts the delivery with no strike.
- Edge detection: bowl and bat are registered once; edge = in & ~in_q. Levels are otherwise ignored.
- Tick: free-running counter 0..TICK_DIV-1; tick is high for one cycle when count==TICK_DIV-1.
- FSM states: IDLE, BOWL, HIT, DONE.
- IDLE:
  - bowl edge and game_over=0 -> next cycle: throw=1, pixelx=START_X, pixely=lane table (lane latched), swing_used=0, state BOWL.
  - bowl edge with game_over=1 -> ignored.
- BOWL (ball_active=1):
  - Bat edge, swing_used=0, HIT_MIN<=pixelx<=HIT_MAX:
    - Latch vx from bat_power, load flight counter = HIT_TICKS, go to HIT.
    - The hit check uses the current pixelx; a coincident tick does not move the ball.
  - Bat edge outside the window -> swing_used=1; all later bat edges this delivery are ignored.
  - Tick with no hit -> pixelx -= STEP_X, clamped to WICKET_X if the result is < WICKET_X (no underflow).
  - Tick when pixelx==WICKET_X -> DONE.
- HIT (ball_active=1):
  - On each tick: pixelx = min(pixelx+vx, X_MAX); flight counter decrements.
  - Counter reaching 0 -> DONE.
  - pixely is unchanged.
- DONE: strike=1 for exactly this cycle, with final coordinates; ball_active=0; next state IDLE.
- Coordinates hold in IDLE until the next throw.
- bowl edges during BOWL/HIT/DONE are ignored. game_over rising mid-flight does not abort the delivery.
- Analyzer mapping (informative): x==7 with y in 175..230 is an out; y=160 at the stumps scores zero.

Decomposition:
- Package ball_flight_pkg holds:
  - state enum;
  - lane-to-y table;
  - default constants for START_X, WICKET_X, HIT_MIN, HIT_MAX and the analyzer zone boundaries.
- Sub-module motion_tick_gen (parameter TICK_DIV): clock, reset, tick output. It is reused by the sprite drawer.

Test Plan:
1. TICK_DIV=4, lane=2, bowl edge, no bat -> throw for exactly 1 cycle. pixelx steps 300,296,…,8, then clamps to 7. strike pulses with pixelx=7, pixely=200. ball_active falls in the strike cycle.
2. lane=1, bat_power=1, bat edge while pixelx=20 -> strike 16 ticks later with pixelx=84, pixely=180. No throw during the flight.
3. Bat edge at pixelx=100, then again at pixelx=20 -> the second edge is ignored. Ball ends at pixelx=7, and strike is asserted once.
4. game_over=1 and bowl edge -> no throw, state stays IDLE, pixelx/pixely unchanged. With game_over=0 the next bowl edge starts normally.
5. Reset asserted mid-BOWL at pixelx=200 -> the next cycle shows all outputs 0 and IDLE. No strike for the next 100 ticks.
6. bat_power=3, bat edge at pixelx=20 coinciding with a tick -> hit registers at x=20 (no move that tick). Landing pixelx=148, strike asserted once.
